multi_oneshot: RTL and testbench

Parametrised, multi-channel successor to the single-input one-shot used for board buttons and switches. Each channel:
- synchronises its raw input;
- debounces it over a programmable cycle count;
- emits single-cycle pulses on a run-time selectable edge, with an optional keyboard-style auto-repeat while held.

It sits between the raw button/switch pins and the lab datapath control logic, replacing ad-hoc per-button one-shots.

---
 rtl/multi_oneshot.sv | 151 +++++++++++++++
 tb/tb_multi_oneshot.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_oneshot.sv
// multi_oneshot: per-channel synchroniser, debouncer and edge one-shot with
// optional keyboard-style auto-repeat. Channels are fully independent; the
// edge mode is shared.
module multi_oneshot #(
  parameter int unsigned CHANNELS        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] os,
  output logic                any_os
);

  localparam int unsigned DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RDW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int unsigned RPW = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int unsigned RW  = (RDW > RPW) ? RDW : RPW;

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] MODE_RISE   = 2'b00;
  localparam logic [1:0] MODE_FALL   = 2'b01;
  localparam logic [1:0] MODE_BOTH   = 2'b10;
  localparam logic [1:0] MODE_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    ZERO   = 2'b00,
    HELD   = 2'b01,
    REPEAT = 2'b10
  } state_e;

  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] os_q, os_d;
  logic [DW-1:0]       dcnt_q [CHANNELS];
  logic [DW-1:0]       dcnt_d [CHANNELS];
  logic [RW-1:0]       rcnt_q [CHANNELS];
  logic [RW-1:0]       rcnt_d [CHANNELS];
  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CHANNELS-1:0] flip, rise, fall;

  // Next-state: synchroniser shift, debounce counting, edge/repeat pulse generation
  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
    level_d = level_q;
    os_d    = '0;
    flip    = '0;
    rise    = '0;
    fall    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      dcnt_d[i]  = '0;
      rcnt_d[i]  = rcnt_q[i];
      state_d[i] = state_q[i];

      if (sync2_q[i] != level_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          flip[i]    = 1'b1;
          level_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
      rise[i] = flip[i] & sync2_q[i];
      fall[i] = flip[i] & ~sync2_q[i];

      case (mode)
        MODE_RISE:   os_d[i] = rise[i];
        MODE_FALL:   os_d[i] = fall[i];
        MODE_BOTH:   os_d[i] = flip[i];
        MODE_REPEAT: os_d[i] = rise[i];
        default:     os_d[i] = 1'b0;
      endcase

      case (state_q[i])
        ZERO: begin
          if (rise[i] && (mode == MODE_REPEAT)) begin
            state_d[i] = HELD;
            rcnt_d[i]  = '0;
          end
        end
        HELD: begin
          if (fall[i] || (mode != MODE_REPEAT)) begin
            state_d[i] = ZERO;
            rcnt_d[i]  = '0;
          end else if (rcnt_q[i] == RD_LAST) begin
            os_d[i]    = 1'b1;
            rcnt_d[i]  = '0;
            state_d[i] = REPEAT;
          end else begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
          end
        end
        REPEAT: begin
          if (fall[i] || (mode != MODE_REPEAT)) begin
            state_d[i] = ZERO;
            rcnt_d[i]  = '0;
          end else if (rcnt_q[i] == RP_LAST) begin
            os_d[i]   = 1'b1;
            rcnt_d[i] = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
          end
        end
        default: begin
          state_d[i] = ZERO;
          rcnt_d[i]  = '0;
        end
      endcase
    end
  end

  // All state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      os_q    <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        dcnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
        state_q[i] <= ZERO;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      os_q    <= os_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        dcnt_q[i]  <= dcnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign level  = level_q;
  assign os     = os_q;
  assign any_os = |os_q;

endmodule

// File: tb/tb_multi_oneshot.sv
// Bench for multi_oneshot: behavioural model compared every cycle, plus
// directed scenarios with hand-computed pulse timing.
module tb_multi_oneshot;

  localparam int CH = 3;
  localparam int DB = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] in = '0;
  logic [1:0]    mode = 2'b00;
  logic [CH-1:0] level, os;
  logic          any_os;

  int checks = 0;
  int failures = 0;

  multi_oneshot #(
    .CHANNELS(CH),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in),
    .mode(mode),
    .level(level),
    .os(os),
    .any_os(any_os)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: input delayed two edges, level flips after DB
  // consecutive disagreements, repeat pulses by elapsed time since press.
  logic [CH-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_os = '0;
  int            m_run [CH];
  bit            m_arm [CH];
  int            m_pt  [CH];
  int            m_t = 0;

  initial begin
    for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_arm[c] = 0; m_pt[c] = 0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_os = '0;
        for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_arm[c] = 0; end
      end else begin
        logic [CH-1:0] nos;
        nos = '0;
        m_t++;
        for (int c = 0; c < CH; c++) begin
          bit flp;
          int e;
          flp = 0;
          if (m_s2[c] != m_lvl[c]) begin
            m_run[c]++;
            if (m_run[c] == DB) begin flp = 1; m_run[c] = 0; end
          end else m_run[c] = 0;
          if (flp && m_s2[c]) begin
            if (mode != 2'b01) nos[c] = 1'b1;
            if (mode == 2'b11) begin m_arm[c] = 1; m_pt[c] = m_t; end
          end else if (flp) begin
            if (mode == 2'b01 || mode == 2'b10) nos[c] = 1'b1;
            m_arm[c] = 0;
          end else if (m_arm[c]) begin
            if (mode != 2'b11) m_arm[c] = 0;
            else begin
              e = m_t - m_pt[c];
              if (e == RD || (e > RD && (e - RD) % RP == 0)) nos[c] = 1'b1;
            end
          end
          if (flp) m_lvl[c] = m_s2[c];
        end
        m_s2 = m_s1;
        m_s1 = in;
        m_os = nos;
      end
    end
  end

  // Per-cycle comparison and pulse logging
  int npulse [CH];
  int lastp  [CH];
  int prevp  [CH];
  int pq [$];
  int cyc = 0;
  int nany = 0;

  initial begin
    for (int c = 0; c < CH; c++) begin npulse[c] = 0; lastp[c] = 0; prevp[c] = 0; end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      chk("model_level", 32'(level), 32'(m_lvl));
      chk("model_os", 32'(os), 32'(m_os));
      chk("model_any_os", 32'(any_os), 32'(|m_os));
      if (os != '0) nany++;
      for (int c = 0; c < CH; c++) begin
        if (os[c]) begin
          npulse[c]++;
          prevp[c] = lastp[c];
          lastp[c] = cyc;
          if (c == 0) pq.push_back(cyc);
        end
      end
    end
  end

  task automatic wait_os(input int ch, input int lim);
    bit ok;
    ok = 0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(posedge clk);
      #1;
      if (os[ch]) ok = 1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_os ch%0d: no pulse within %0d cycles", ch, lim);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int rep_off [9] = '{0, 8, 11, 14, 17, 20, 23, 26, 29};
  int base;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_os", 32'(os), 32'h0);
    chk("reset_any", 32'(any_os), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    idle(3);

    // Mode 00: press/hold/release on channel 0
    in[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("s1_level_edge4", 32'(level), 32'h0);
    @(posedge clk);
    #1;
    chk("s1_level_edge5", 32'(level), 32'h1);
    chk("s1_os_edge5", 32'(os), 32'h1);
    @(posedge clk);
    #1;
    chk("s1_os_edge6", 32'(os), 32'h0);
    idle(14);
    in[0] = 1'b0;
    idle(10);
    chk("s1_level_released", 32'(level), 32'h0);
    chk("s1_pulses0", 32'(npulse[0]), 32'd1);
    chk("s1_pulses1", 32'(npulse[1]), 32'd0);
    chk("s1_pulses2", 32'(npulse[2]), 32'd0);

    // Mode 00: glitchy channel 1 never debounces, then settles
    for (int r = 0; r < 5; r++) begin
      in[1] = 1'b1; idle(3);
      in[1] = 1'b0; idle(1);
    end
    in[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("s2_level_glitch", 32'(level[1]), 32'h0);
    chk("s2_pulses_glitch", 32'(npulse[1]), 32'd0);
    @(posedge clk);
    #1;
    chk("s2_os_stable", 32'(os), 32'h2);
    idle(10);
    chk("s2_pulses_hold", 32'(npulse[1]), 32'd1);
    in[1] = 1'b0;
    idle(10);

    // Mode 10: both edges on channel 2, 10 cycles apart
    mode = 2'b10;
    in[2] = 1'b1;
    idle(10);
    in[2] = 1'b0;
    idle(12);
    chk("s3_pulses2", 32'(npulse[2]), 32'd2);
    chk("s3_spacing", 32'(lastp[2] - prevp[2]), 32'd10);

    // Mode 11: auto-repeat, level held for 31 cycles after the press pulse
    mode = 2'b11;
    idle(2);
    pq.delete();
    in[0] = 1'b1;
    wait_os(0, 12);
    repeat (25) @(posedge clk);
    @(negedge clk) in[0] = 1'b0;
    idle(15);
    chk("s4_npulses", 32'(pq.size()), 32'd9);
    if (pq.size() == 9) begin
      base = pq[0];
      for (int k = 0; k < 9; k++) chk("s4_rep_offset", 32'(pq[k] - base), 32'(rep_off[k]));
    end

    // Mode 11 then switch to 00 after the first repeat
    pq.delete();
    in[0] = 1'b1;
    wait_os(0, 12);
    repeat (8) @(posedge clk);
    @(negedge clk) mode = 2'b00;
    idle(20);
    chk("s4b_npulses", 32'(pq.size()), 32'd2);
    if (pq.size() == 2) chk("s4b_first_rep", 32'(pq[1] - pq[0]), 32'd8);
    in[0] = 1'b0;
    idle(10);

    // Mode 01: two channels together, pulse only on release
    mode = 2'b01;
    base = nany;
    in = 3'b101;
    idle(10);
    chk("s5_no_press_pulse", 32'(nany - base), 32'd0);
    chk("s5_level_high", 32'(level), 32'h5);
    in = 3'b000;
    wait_os(0, 12);
    chk("s5_os_release", 32'(os), 32'h5);
    chk("s5_any_release", 32'(any_os), 32'h1);
    @(posedge clk);
    #1;
    chk("s5_os_after", 32'(os), 32'h0);
    idle(3);

    // Mode 00: asynchronous reset mid-debounce, re-press afterwards
    mode = 2'b00;
    in[2] = 1'b1;
    idle(8);
    in[0] = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("s6_level_pre", 32'(level), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("s6_level_async", 32'(level), 32'h0);
    chk("s6_os_async", 32'(os), 32'h0);
    idle(2);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("s6_level_edge4", 32'(level), 32'h0);
    @(posedge clk);
    #1;
    chk("s6_os_edge5", 32'(os), 32'h5);
    chk("s6_level_edge5", 32'(level), 32'h5);
    @(posedge clk);
    #1;
    chk("s6_os_edge6", 32'(os), 32'h0);
    in = '0;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
